// File: rtl/dff_pkg.sv
// Shared defaults and helpers for the d_flip_flop register family.
package dff_pkg;

    localparam int DFF_WIDTH_DEF  = 1;
    localparam int DFF_STAGES_DEF = 1;
    localparam int DFF_PARITY_MAX = 64;

    // Bits needed to count 0..stages inclusive.
    function automatic int cnt_width(input int stages);
        return $clog2(stages + 1);
    endfunction

    // Even parity over a zero-extended value (data up to DFF_PARITY_MAX bits).
    function automatic logic parity(input logic [DFF_PARITY_MAX-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One register stage: 1 enabled edge latency, en=0 holds; sync clr and async active-low reset load RST_VAL.
module dff_stage
    import dff_pkg::*;
#(
    parameter int             W       = DFF_WIDTH_DEF,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (clr) begin
            r_q <= RST_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/d_flip_flop.sv
// Reset-able register/pipeline: STAGES enabled edges d->q latency, en=0 holds everything, clr > en.
// Optional stored even parity with sticky perr output under `define DFF_PARITY_EN.
module d_flip_flop
    import dff_pkg::*;
#(
    parameter int                 WIDTH   = DFF_WIDTH_DEF,
    parameter int                 STAGES  = DFF_STAGES_DEF,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q,
    output logic              vld
`ifdef DFF_PARITY_EN
    ,
    output logic              perr
`endif
);

    localparam int CW = cnt_width(STAGES);

`ifdef DFF_PARITY_EN
    localparam int              SW       = WIDTH + 1;
    localparam logic [SW-1:0]   STG_RST  = {parity(DFF_PARITY_MAX'(RST_VAL)), RST_VAL};
`else
    localparam int              SW       = WIDTH;
    localparam logic [SW-1:0]   STG_RST  = RST_VAL;
`endif

    logic [1:0]     r_rst_sync;
    logic           w_en;
    logic [SW-1:0]  w_chain [0:STAGES];
    logic [CW-1:0]  r_cnt;

    // Reset assertion is immediate; release is held off two edges so no
    // capture happens on an edge too close to rst rising.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_en = en & r_rst_sync[1];

`ifdef DFF_PARITY_EN
    assign w_chain[0] = {parity(DFF_PARITY_MAX'(d)), d};
`else
    assign w_chain[0] = d;
`endif

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        dff_stage #(
            .W       (SW),
            .RST_VAL (STG_RST)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst),
            .clr   (clr),
            .en    (w_en),
            .d     (w_chain[gi]),
            .q     (w_chain[gi+1])
        );
    end

    assign q = w_chain[STAGES][WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_en && (r_cnt != CW'(STAGES))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign vld = (r_cnt == CW'(STAGES));

`ifdef DFF_PARITY_EN
    logic r_perr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perr <= 1'b0;
        end else if (clr) begin
            r_perr <= 1'b0;
        end else if (parity(DFF_PARITY_MAX'(q)) != w_chain[STAGES][WIDTH]) begin
            r_perr <= 1'b1;
        end
    end

    assign perr = r_perr;
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// Randomised scoreboard bench for d_flip_flop configured as an 8-bit, 3-stage pipeline.
module tb_d_flip_flop;

    localparam int           W  = 8;
    localparam int           S  = 3;
    localparam logic [W-1:0] RV = 8'h3C;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] d   = '0;
    logic [W-1:0] q;
    logic         vld;
`ifdef DFF_PARITY_EN
    logic         perr;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic         vld;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] pipe[$];
    int           loads = 0;

    always #10 clk = ~clk;

    d_flip_flop #(
        .WIDTH   (W),
        .STAGES  (S),
        .RST_VAL (RV)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .d    (d),
        .q    (q),
        .vld  (vld)
`ifdef DFF_PARITY_EN
        ,
        .perr (perr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the pipe holds the last S accepted words, oldest at the front.
    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < S; i++) pipe.push_back(RV);
        loads = 0;
    endtask

    // Called between edges; drives inputs for the coming edge and queues the
    // response that edge must produce, then returns at the following negedge.
    task automatic step(input logic e, input logic c, input logic [W-1:0] dv, input bit no_cap);
        en  = e;
        clr = c;
        d   = dv;
        if (c) begin
            model_reset();
        end else if (e && !no_cap) begin
            pipe.push_back(dv);
            void'(pipe.pop_front());
            if (loads < S) loads++;
        end
        sb.push_back('{q: pipe[0], vld: (loads == S)});
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", 32'(q), 32'(e.q));
                chk("vld", 32'(vld), 32'(e.vld));
`ifdef DFF_PARITY_EN
                chk("perr", 32'(perr), 32'd0);
`endif
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        repeat (4) begin
            @(negedge clk);
            en = 1'b1;
            d  = W'($urandom);
            chk("rst_q", 32'(q), 32'(RV));
            chk("rst_vld", 32'(vld), 32'd0);
        end

        rst = 1'b1;
        step(1'b1, 1'b0, 8'hC3, 1'b1);
        step(1'b0, 1'b0, W'($urandom), 1'b0);

        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        step(1'b1, 1'b0, 8'h44, 1'b0);
        step(1'b1, 1'b0, 8'h55, 1'b0);
        step(1'b1, 1'b0, 8'h66, 1'b0);

        repeat (5) step(1'b0, 1'b0, W'($urandom), 1'b0);

        step(1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b0, 1'b0, 8'hFF, 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'hA5, 1'b0);

        @(posedge clk);
        #5;
        rst = 1'b0;
        #1;
        chk("async_q", 32'(q), 32'(RV));
        chk("async_vld", 32'(vld), 32'd0);
        model_reset();
        @(negedge clk);
        d = 8'h5A;
        chk("held_q", 32'(q), 32'(RV));
        chk("held_vld", 32'(vld), 32'd0);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h96, 1'b1);
        step(1'b0, 1'b0, 8'h69, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(3) != 0),
                 ($urandom_range(15) == 0),
                 W'($urandom), 1'b0);
        end

        en  = 1'b0;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
